sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO that follows on from the 2-entry FIFO. It generalises width and depth and adds a selectable read mode: first-word-fall-through or registered read. It also adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It sits between a producer using push/full and a consumer using pop/empty, in the same clock domain.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 4, number of entries (>=2, need not be a power of two)
AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1)
FWFT, 1, 1 = head word visible on rdata while not empty; 0 = rdata registered one cycle after pop

Ports:
clk  input  1  single clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
push  input  1  write request
wdata  input  WIDTH  write data, sampled with an accepted push
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_THRESH
pop  input  1  read request
rdata  output  WIDTH  read data
rvalid  output  1  rdata is valid
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected

Behaviour:
- Reset (asynchronous assert, synchronous effect on release):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0, rvalid=0, rdata=0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all entries immediately. No pulse of any kind is produced.
- Pointers:
  - Binary, range 0..DEPTH-1.
  - Each pointer wraps to 0 after DEPTH-1, with explicit compare; no power-of-two masking.
- Acceptance, evaluated on current registered state:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - Push while full is accepted if a pop is accepted in the same cycle: count is unchanged, no overflow.
- Count update:
  - count_next = count + push_ok - pop_ok.
  - All flags are registered, derived from count_next, and valid in the cycle after the update.
- Empty with push and pop in the same cycle:
  - Pop is rejected and underflow pulses; push is accepted.
  - count becomes 1. A new word is never bypassed to rdata in the same cycle.
- Error pulses:
  - overflow=1 for exactly one cycle after a cycle with push & ~push_ok.
  - underflow=1 for exactly one cycle after a cycle with pop & empty.
  - Rejected requests change no state.
- FWFT=1:
  - rdata = mem[rd_ptr] (combinational from storage); rvalid = ~empty.
  - The first pushed word appears on rdata one cycle after the push, the same cycle empty falls.
  - An accepted pop advances rd_ptr; the next word is visible the following cycle.
- FWFT=0:
  - On pop_ok, rdata <= mem[rd_ptr] and rvalid <= 1. Otherwise rvalid <= 0 and rdata holds its value.
  - Read latency is 1 cycle from the accepted pop.
- Ordering: strict FIFO order. No data loss except rejected pushes.
- Protocol requirement on the producer: push only when full was 0 in the previous cycle, unless it pops in the same cycle. Violations are tolerated and flagged via overflow.

Test Plan:
- Reset and idle:
  - Hold reset 2 cycles, release at negedge, with DEPTH=4.
  - Required: empty=1, almost_empty=1, full=0, count=0, rvalid=0, rdata=0, no pulses for 10 idle cycles.
- Fill and drain, FWFT=1, WIDTH=8, DEPTH=4:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: count 1→4; almost_full at count=3; full=1 after 4th push.
  - Then pop 4 times. Required: rdata 0x11, 0x22, 0x33, 0x44 in order; empty=1 and count=0 at the end; rd_ptr wraps to 0.
- Overflow and full bypass:
  - At full, push 0x55 with no pop. Required: overflow=1 for one cycle; count stays 4; 0x55 is never read.
  - Next cycle, push 0x66 together with a pop. Required: both accepted; count stays 4; 0x66 is read last.
- Underflow and the empty corner:
  - Pop while empty. Required: underflow pulse, count=0.
  - Push 0xA5 and pop in the same cycle while empty. Required: underflow pulse, count=1, rdata=0xA5 next cycle.
- Registered mode, FWFT=0, DEPTH=3:
  - Push 0x01, 0x02, 0x03, then pop on three back-to-back cycles.
  - Required: rvalid high for exactly 3 cycles, each starting 1 cycle after its pop; rdata 0x01, 0x02, 0x03; pointers wrap at non-power-of-two depth.
- Reset mid-operation:
  - With count=2, assert reset asynchronously between clock edges.
  - Required: count=0, empty=1, rvalid=0 immediately; after release, a push of 0x7E reads back 0x7E and no stale data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock FIFO with parametrised width and depth (depth need not be a
// power of two). It has a selectable read mode: first-word-fall-through or
// registered read. It also provides an occupancy count, almost-full and
// almost-empty flags, and one-cycle overflow/underflow error pulses.
//
// Parameters:
//   WIDTH          data width in bits (>= 1)
//   DEPTH          number of entries (>= 2)
//   AFULL_THRESH   almost_full  when count >= AFULL_THRESH (1..DEPTH)
//   AEMPTY_THRESH  almost_empty when count <= AEMPTY_THRESH (0..DEPTH-1)
//   FWFT           1: head word shown on rdata while not empty
//                  0: rdata registered one cycle after an accepted pop
//
// Ports:
//   clk           clock, all logic on posedge
//   reset         asynchronous, active-high reset
//   push, wdata   write request and its data
//   full          count == DEPTH
//   almost_full   count >= AFULL_THRESH
//   pop           read request
//   rdata, rvalid read data and its qualifier
//   empty         count == 0
//   almost_empty  count <= AEMPTY_THRESH
//   count         current occupancy
//   overflow      one-cycle pulse after a rejected push
//   underflow     one-cycle pulse after a rejected pop
//
// Handshake: a push is accepted on a posedge when full is low, or when a pop
// is accepted in that same cycle. A pop is accepted on a posedge when empty
// is low. Both decisions use only the registered flags, so a word pushed into
// an empty FIFO can never be popped in the same cycle. Rejected requests
// leave all state untouched and only raise the matching error pulse.
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 1,
    localparam int CW           = $clog2(DEPTH + 1),
    localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             almost_full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_next;
    logic [CW-1:0]    count_next;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Explicit wrap compare so non-power-of-two depths work.
    assign wr_ptr_next = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    assign rd_ptr_next = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

    assign count_next = count + CW'(push_ok) - CW'(pop_ok);

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, flags and error pulses. Flags are computed from
    // count_next so they line up with the registered count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr_next;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_next;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(AEMPTY_THRESH));
            almost_full  <= (count_next >= CW'(AFULL_THRESH));
            overflow     <= push & ~push_ok;
            underflow    <= pop & empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero while empty so rdata
            // is defined out of reset even though storage is not.
            assign rdata  = empty ? '0 : mem[rd_ptr];
            assign rvalid = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // rdata holds its last value when no pop is accepted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (pop_ok) begin
                    rdata_q  <= mem[rd_ptr];
                    rvalid_q <= 1'b1;
                end else begin
                    rvalid_q <= 1'b0;
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed bench for sync_fifo_param. Instance a runs in fall-through mode
// with depth 4, and instance b runs in registered-read mode with depth 3.
// Inputs change right after a negedge. Outputs are read at the following
// negedge, so each read shows the effect of the posedge in between.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;

    logic       a_push, a_pop;
    logic [7:0] a_wdata, a_rdata;
    logic       a_full, a_almost_full, a_rvalid, a_empty, a_almost_empty;
    logic [2:0] a_count;
    logic       a_overflow, a_underflow;

    logic       b_push, b_pop;
    logic [7:0] b_wdata, b_rdata;
    logic       b_full, b_almost_full, b_rvalid, b_empty, b_almost_empty;
    logic [1:0] b_count;
    logic       b_overflow, b_underflow;

    int n_checks;
    int n_pass;
    logic [7:0] exp_q[$];

    sync_fifo_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_a (
        .clk(clk), .reset(reset),
        .push(a_push), .wdata(a_wdata), .full(a_full), .almost_full(a_almost_full),
        .pop(a_pop), .rdata(a_rdata), .rvalid(a_rvalid), .empty(a_empty),
        .almost_empty(a_almost_empty), .count(a_count),
        .overflow(a_overflow), .underflow(a_underflow)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(3), .FWFT(0)) u_b (
        .clk(clk), .reset(reset),
        .push(b_push), .wdata(b_wdata), .full(b_full), .almost_full(b_almost_full),
        .pop(b_pop), .rdata(b_rdata), .rvalid(b_rvalid), .empty(b_empty),
        .almost_empty(b_almost_empty), .count(b_count),
        .overflow(b_overflow), .underflow(b_underflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: apply one cycle of requests, return at the next negedge.
    task automatic drive_a(input logic p, input logic [7:0] wd, input logic q);
        a_push = p; a_wdata = wd; a_pop = q;
        @(negedge clk);
        a_push = 1'b0; a_pop = 1'b0;
    endtask

    task automatic drive_b(input logic p, input logic [7:0] wd, input logic q);
        b_push = p; b_wdata = wd; b_pop = q;
        @(negedge clk);
        b_push = 1'b0; b_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({a_empty, a_almost_empty, a_full, a_almost_full, a_rvalid} !== 5'b11000)
            $display("FAIL reset_a_flags: got %b exp 11000",
                     {a_empty, a_almost_empty, a_full, a_almost_full, a_rvalid});
        else n_pass++;
        n_checks++;
        if (a_count !== 3'd0 || a_rdata !== 8'h00)
            $display("FAIL reset_a_count_rdata: got %0d/%h exp 0/00", a_count, a_rdata);
        else n_pass++;
        n_checks++;
        if ({b_empty, b_almost_empty, b_full, b_rvalid} !== 4'b1100 || b_count !== 2'd0 || b_rdata !== 8'h00)
            $display("FAIL reset_b: got flags %b count %0d rdata %h exp 1100/0/00",
                     {b_empty, b_almost_empty, b_full, b_rvalid}, b_count, b_rdata);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            drive_a(1'b0, 8'h00, 1'b0);
            n_checks++;
            if ({a_overflow, a_underflow, b_overflow, b_underflow} !== 4'b0000 || a_empty !== 1'b1)
                $display("FAIL idle_%0d: got pulses %b empty %b exp 0000/1", i,
                         {a_overflow, a_underflow, b_overflow, b_underflow}, a_empty);
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        logic [7:0] exp_d;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, vals[i], 1'b0);
            exp_q.push_back(vals[i]);
            n_checks++;
            if (a_count !== 3'(i + 1) || a_almost_full !== (i + 1 >= 3) || a_full !== (i == 3))
                $display("FAIL fill_%0d: got count %0d af %b full %b exp %0d/%b/%b", i,
                         a_count, a_almost_full, a_full, i + 1, (i + 1 >= 3), (i == 3));
            else n_pass++;
            n_checks++;
            if (a_rdata !== 8'h11 || a_rvalid !== 1'b1 || a_empty !== 1'b0)
                $display("FAIL fill_head_%0d: got rdata %h rvalid %b empty %b exp 11/1/0",
                         i, a_rdata, a_rvalid, a_empty);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (a_rdata !== exp_d)
                $display("FAIL drain_data_%0d: got %h exp %h", i, a_rdata, exp_d);
            else n_pass++;
            drive_a(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (a_count !== 3'(3 - i))
                $display("FAIL drain_count_%0d: got %0d exp %0d", i, a_count, 3 - i);
            else n_pass++;
        end
        n_checks++;
        if (a_empty !== 1'b1 || a_rvalid !== 1'b0 || u_a.rd_ptr !== 2'd0)
            $display("FAIL drain_end: got empty %b rvalid %b rd_ptr %0d exp 1/0/0",
                     a_empty, a_rvalid, u_a.rd_ptr);
        else n_pass++;
    endtask

    task automatic test_overflow_bypass();
        logic [7:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 8'h81 + 8'(i), 1'b0);
            exp_q.push_back(8'h81 + 8'(i));
        end
        drive_a(1'b1, 8'h55, 1'b0);
        n_checks++;
        if (a_overflow !== 1'b1 || a_count !== 3'd4 || a_full !== 1'b1)
            $display("FAIL overflow_pulse: got ovf %b count %0d full %b exp 1/4/1",
                     a_overflow, a_count, a_full);
        else n_pass++;
        exp_d = exp_q.pop_front();
        n_checks++;
        if (a_rdata !== exp_d)
            $display("FAIL bypass_head: got %h exp %h", a_rdata, exp_d);
        else n_pass++;
        drive_a(1'b1, 8'h66, 1'b1);
        exp_q.push_back(8'h66);
        n_checks++;
        if (a_overflow !== 1'b0 || a_count !== 3'd4 || a_full !== 1'b1)
            $display("FAIL bypass_push_pop: got ovf %b count %0d full %b exp 0/4/1",
                     a_overflow, a_count, a_full);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (a_rdata !== exp_d)
                $display("FAIL bypass_drain_%0d: got %h exp %h", i, a_rdata, exp_d);
            else n_pass++;
            drive_a(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (a_count !== 3'd0 || a_empty !== 1'b1 || a_underflow !== 1'b0)
            $display("FAIL bypass_end: got count %0d empty %b unf %b exp 0/1/0",
                     a_count, a_empty, a_underflow);
        else n_pass++;
    endtask

    task automatic test_underflow();
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (a_underflow !== 1'b1 || a_count !== 3'd0 || a_empty !== 1'b1)
            $display("FAIL underflow_pulse: got unf %b count %0d empty %b exp 1/0/1",
                     a_underflow, a_count, a_empty);
        else n_pass++;
        drive_a(1'b1, 8'hA5, 1'b1);
        n_checks++;
        if (a_underflow !== 1'b1 || a_count !== 3'd1 || a_rdata !== 8'hA5 || a_rvalid !== 1'b1)
            $display("FAIL empty_push_pop: got unf %b count %0d rdata %h rvalid %b exp 1/1/a5/1",
                     a_underflow, a_count, a_rdata, a_rvalid);
        else n_pass++;
        drive_a(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (a_underflow !== 1'b0 || a_count !== 3'd1)
            $display("FAIL underflow_one_cycle: got unf %b count %0d exp 0/1", a_underflow, a_count);
        else n_pass++;
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (a_count !== 3'd0 || a_empty !== 1'b1 || a_underflow !== 1'b0)
            $display("FAIL underflow_drain: got count %0d empty %b unf %b exp 0/1/0",
                     a_count, a_empty, a_underflow);
        else n_pass++;
    endtask

    task automatic test_registered();
        logic [7:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b1, 8'(i + 1), 1'b0);
            exp_q.push_back(8'(i + 1));
            n_checks++;
            if (b_rvalid !== 1'b0 || b_count !== 2'(i + 1))
                $display("FAIL reg_fill_%0d: got rvalid %b count %0d exp 0/%0d",
                         i, b_rvalid, b_count, i + 1);
            else n_pass++;
        end
        n_checks++;
        if (b_full !== 1'b1 || b_almost_full !== 1'b1 || u_b.wr_ptr !== 2'd0)
            $display("FAIL reg_full: got full %b af %b wr_ptr %0d exp 1/1/0",
                     b_full, b_almost_full, u_b.wr_ptr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b0, 8'h00, 1'b1);
            exp_d = exp_q.pop_front();
            n_checks++;
            if (b_rvalid !== 1'b1 || b_rdata !== exp_d)
                $display("FAIL reg_pop_%0d: got rvalid %b rdata %h exp 1/%h", i, b_rvalid, b_rdata, exp_d);
            else n_pass++;
        end
        drive_b(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (b_rvalid !== 1'b0 || b_rdata !== 8'h03 || b_empty !== 1'b1 || u_b.rd_ptr !== 2'd0)
            $display("FAIL reg_after: got rvalid %b rdata %h empty %b rd_ptr %0d exp 0/03/1/0",
                     b_rvalid, b_rdata, b_empty, u_b.rd_ptr);
        else n_pass++;
        drive_b(1'b1, 8'h04, 1'b0);
        drive_b(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 8'h04 || b_count !== 2'd0)
            $display("FAIL reg_wrap: got rvalid %b rdata %h count %0d exp 1/04/0",
                     b_rvalid, b_rdata, b_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_a(1'b1, 8'h31, 1'b0);
        drive_a(1'b1, 8'h32, 1'b0);
        n_checks++;
        if (a_count !== 3'd2)
            $display("FAIL mid_pre_count: got %0d exp 2", a_count);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (a_count !== 3'd0 || a_empty !== 1'b1 || a_rvalid !== 1'b0)
            $display("FAIL mid_reset_async: got count %0d empty %b rvalid %b exp 0/1/0",
                     a_count, a_empty, a_rvalid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        drive_a(1'b1, 8'h7E, 1'b0);
        n_checks++;
        if (a_rdata !== 8'h7E || a_count !== 3'd1 || a_overflow !== 1'b0 || a_underflow !== 1'b0)
            $display("FAIL mid_readback: got rdata %h count %0d ovf %b unf %b exp 7e/1/0/0",
                     a_rdata, a_count, a_overflow, a_underflow);
        else n_pass++;
        drive_a(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (a_empty !== 1'b1 || a_count !== 3'd0)
            $display("FAIL mid_no_stale: got empty %b count %0d exp 1/0", a_empty, a_count);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        a_push = 1'b0; a_pop = 1'b0; a_wdata = 8'h00;
        b_push = 1'b0; b_pop = 1'b0; b_wdata = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow_bypass();
        test_underflow();
        test_registered();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
